// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR cipher job sequencer.
// Holds the FSM state encoding and the default key/message sizes and timeout.
// Imported by the sequencer top and its wait timer.
package xor_cipher_pkg;

  localparam int KEY_SIZE_DEF = 32;
  localparam int MSG_SIZE_DEF = 512;
  localparam int TIMEOUT_DEF  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_LOAD_MSG = 3'd2,
    ST_ENCRYPT  = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;

  // States in which the wait timer is allowed to run.
  function automatic logic is_wait_state(state_t s);
    return (s == ST_ENCRYPT) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/xor_cipher_sequencer_if.sv
// Host/datapath bundle of the XOR cipher sequencer.
// master: host side drives the i* requests and events, observes the o* status.
// slave:  sequencer side consumes i* and drives o*.
interface xor_cipher_sequencer_if;

  logic       iStart;
  logic       iAbort;
  logic       iBit_valid;
  logic       iBit;
  logic       iEncrypt_done;
  logic       iSerial_end;
  logic       oData_bit;
  logic       oLoad_key;
  logic       oLoad_msg;
  logic       oBusy;
  logic       oDone;
  logic       oError;
  logic [2:0] oState;

  modport master (
    output iStart, iAbort, iBit_valid, iBit, iEncrypt_done, iSerial_end,
    input  oData_bit, oLoad_key, oLoad_msg, oBusy, oDone, oError, oState
  );

  modport slave (
    input  iStart, iAbort, iBit_valid, iBit, iEncrypt_done, iSerial_end,
    output oData_bit, oLoad_key, oLoad_msg, oBusy, oDone, oError, oState
  );

endinterface

// File: rtl/xor_seq_timer.sv
// Clearable wait counter; tc high once the count reaches TIMEOUT-1.
// Latency: clear/increment take effect on the next rising edge; tc is a decode of the register.
// Backpressure: none; holds while ena is low and saturates at terminal count (never wraps).
// Ports: clk, rst_n (async active-low), ena (hold when low), clr (sync clear), tc (terminal flag).
module xor_seq_timer
  import xor_cipher_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clr,
  output logic tc
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [TW-1:0] cnt;

  assign tc = (cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (clr) begin
        cnt <= '0;
      end else if (!tc) begin
        cnt <= cnt + TW'(1);
      end
    end
  end

endmodule

// File: rtl/xor_cipher_sequencer.sv
// Job sequencer: loads a serial key then message, waits on encryptor and serializer, reports done/timeout.
// Latency: each accepted serial bit appears as oData_bit plus a load strobe one cycle later.
// Backpressure: none on the bit stream; waits are bounded by TIMEOUT, then sticky oError in ERROR.
// Ports: clk, rst_n (async active-low), ena (global hold), bus (slave side of the host bundle).
module xor_cipher_sequencer
  import xor_cipher_pkg::*;
#(
  parameter int KEY_SIZE = KEY_SIZE_DEF,
  parameter int MSG_SIZE = MSG_SIZE_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  xor_cipher_sequencer_if.slave  bus
);

  localparam int CW = $clog2(MSG_SIZE) + 1;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic          data_bit;
  logic          load_key;
  logic          load_msg;
  logic          error_q;
  logic          tmr_clr;
  logic          tmr_tc;

  // Timer is held at zero outside the wait states, so it starts from 0 on entering
  // ENCRYPT; it is also cleared on the ENCRYPT->DRAIN edge so DRAIN gets a fresh budget.
  assign tmr_clr = !is_wait_state(state) ||
                   ((state == ST_ENCRYPT) && bus.iEncrypt_done);

  xor_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .clr   (tmr_clr),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      data_bit <= 1'b0;
      load_key <= 1'b0;
      load_msg <= 1'b0;
      error_q  <= 1'b0;
    end else if (!ena) begin
      load_key <= 1'b0;
      load_msg <= 1'b0;
    end else begin
      // Strobes are single-cycle by default; only an accepted bit raises one.
      load_key <= 1'b0;
      load_msg <= 1'b0;
      if (bus.iAbort) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        error_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.iStart) begin
              state   <= ST_LOAD_KEY;
              bit_cnt <= '0;
            end
          end
          ST_LOAD_KEY: begin
            if (bus.iBit_valid) begin
              load_key <= 1'b1;
              data_bit <= bus.iBit;
              if (bit_cnt == CW'(KEY_SIZE - 1)) begin
                state   <= ST_LOAD_MSG;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
          ST_LOAD_MSG: begin
            if (bus.iBit_valid) begin
              load_msg <= 1'b1;
              data_bit <= bus.iBit;
              if (bit_cnt == CW'(MSG_SIZE - 1)) begin
                state   <= ST_ENCRYPT;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
          // Awaited event is tested before the timeout so a coincident event wins.
          ST_ENCRYPT: begin
            if (bus.iEncrypt_done) begin
              state <= ST_DRAIN;
            end else if (tmr_tc) begin
              state   <= ST_ERROR;
              error_q <= 1'b1;
            end
          end
          ST_DRAIN: begin
            if (bus.iSerial_end) begin
              state <= ST_DONE;
            end else if (tmr_tc) begin
              state   <= ST_ERROR;
              error_q <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          ST_ERROR: begin
            if (bus.iStart) begin
              state   <= ST_LOAD_KEY;
              bit_cnt <= '0;
              error_q <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.oData_bit = data_bit;
  assign bus.oLoad_key = load_key;
  assign bus.oLoad_msg = load_msg;
  assign bus.oBusy     = (state != ST_IDLE);
  assign bus.oDone     = (state == ST_DONE);
  assign bus.oError    = error_q;
  assign bus.oState    = state;

endmodule

// File: tb/tb_xor_cipher_sequencer.sv
// Directed bench for xor_cipher_sequencer at default sizes (32-bit key, 512-bit message, 1024 timeout).
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Ports: drives the master side of the bundle plus clk, rst_n and ena.
module tb_xor_cipher_sequencer;

  localparam int KEY_BITS = 32;
  localparam int MSG_BITS = 512;
  localparam int TMO      = 1024;

  logic clk;
  logic rst_n;
  logic ena;

  int errors = 0;
  int checks = 0;

  xor_cipher_sequencer_if bus ();

  xor_cipher_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic pat(input int i);
    return logic'(((i ^ (i >> 2)) & 1) != 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job();
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
  endtask

  task automatic abort_job();
    bus.iAbort = 1'b1;
    tick();
    bus.iAbort = 1'b0;
  endtask

  // Feeds n consecutive bits starting at global index first; tallies strobes and data errors.
  task automatic send_bits(input int first, input int n,
                           output int key_hi, output int msg_hi, output int bad_dat);
    key_hi  = 0;
    msg_hi  = 0;
    bad_dat = 0;
    for (int i = first; i < first + n; i++) begin
      bus.iBit_valid = 1'b1;
      bus.iBit       = pat(i);
      tick();
      key_hi += int'(bus.oLoad_key);
      msg_hi += int'(bus.oLoad_msg);
      if (bus.oData_bit !== pat(i)) bad_dat++;
    end
    bus.iBit_valid = 1'b0;
    bus.iBit       = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({bus.oData_bit, bus.oLoad_key, bus.oLoad_msg, bus.oBusy, bus.oDone, bus.oError, bus.oState} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {bus.oData_bit, bus.oLoad_key, bus.oLoad_msg, bus.oBusy, bus.oDone, bus.oError, bus.oState});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.oState !== 3'd0) begin
      errors++;
      $display("FAIL idle_after_release: state %0d want 0", bus.oState);
    end
    start_job();
    checks++;
    if (bus.oState !== 3'd1 || bus.oBusy !== 1'b1) begin
      errors++;
      $display("FAIL first_start: state %0d busy %b want 1/1", bus.oState, bus.oBusy);
    end
    abort_job();
  endtask

  task automatic test_full_job();
    int kh, mh, bd, kt, mt, bt, strobes;
    start_job();
    send_bits(0, KEY_BITS, kh, mh, bd);
    kt = kh; mt = mh; bt = bd;
    checks++;
    if (bus.oState !== 3'd2) begin
      errors++;
      $display("FAIL key_to_msg: state %0d want 2", bus.oState);
    end
    send_bits(KEY_BITS, MSG_BITS - 1, kh, mh, bd);
    kt += kh; mt += mh; bt += bd;
    checks++;
    if (bus.oState !== 3'd2) begin
      errors++;
      $display("FAIL msg_not_early: state %0d want 2", bus.oState);
    end
    send_bits(KEY_BITS + MSG_BITS - 1, 1, kh, mh, bd);
    kt += kh; mt += mh; bt += bd;
    checks++;
    if (bus.oState !== 3'd3) begin
      errors++;
      $display("FAIL msg_to_encrypt: state %0d want 3", bus.oState);
    end
    checks++;
    if (kt != KEY_BITS || mt != MSG_BITS) begin
      errors++;
      $display("FAIL strobe_counts: key %0d msg %0d want %0d %0d", kt, mt, KEY_BITS, MSG_BITS);
    end
    checks++;
    if (bt != 0) begin
      errors++;
      $display("FAIL data_bits: %0d wrong want 0", bt);
    end
    // Extra bit in ENCRYPT is ignored.
    bus.iBit_valid = 1'b1;
    tick();
    bus.iBit_valid = 1'b0;
    strobes = int'(bus.oLoad_key) + int'(bus.oLoad_msg);
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL bit_in_encrypt: strobes %0d want 0", strobes);
    end
    repeat (3) tick();
    bus.iEncrypt_done = 1'b1;
    tick();
    bus.iEncrypt_done = 1'b0;
    checks++;
    if (bus.oState !== 3'd4) begin
      errors++;
      $display("FAIL encrypt_to_drain: state %0d want 4", bus.oState);
    end
    repeat (519) tick();
    checks++;
    if (bus.oState !== 3'd4 || bus.oDone !== 1'b0) begin
      errors++;
      $display("FAIL drain_wait: state %0d done %b want 4/0", bus.oState, bus.oDone);
    end
    bus.iSerial_end = 1'b1;
    tick();
    bus.iSerial_end = 1'b0;
    checks++;
    if (bus.oState !== 3'd5 || bus.oDone !== 1'b1 || bus.oBusy !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: state %0d done %b busy %b want 5/1/1", bus.oState, bus.oDone, bus.oBusy);
    end
    tick();
    checks++;
    if (bus.oState !== 3'd0 || bus.oDone !== 1'b0 || bus.oBusy !== 1'b0 || bus.oError !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: state %0d done %b busy %b err %b want 0/0/0/0", bus.oState, bus.oDone, bus.oBusy, bus.oError);
    end
  endtask

  task automatic test_timeout();
    int kh, mh, bd;
    start_job();
    send_bits(0, KEY_BITS + MSG_BITS, kh, mh, bd);
    repeat (TMO - 1) tick();
    checks++;
    if (bus.oState !== 3'd3 || bus.oError !== 1'b0) begin
      errors++;
      $display("FAIL timeout_not_early: state %0d err %b want 3/0", bus.oState, bus.oError);
    end
    tick();
    checks++;
    if (bus.oState !== 3'd6 || bus.oError !== 1'b1) begin
      errors++;
      $display("FAIL timeout_error: state %0d err %b want 6/1", bus.oState, bus.oError);
    end
    repeat (3) tick();
    checks++;
    if (bus.oState !== 3'd6 || bus.oError !== 1'b1) begin
      errors++;
      $display("FAIL error_holds: state %0d err %b want 6/1", bus.oState, bus.oError);
    end
    start_job();
    checks++;
    if (bus.oState !== 3'd1 || bus.oError !== 1'b0) begin
      errors++;
      $display("FAIL error_restart: state %0d err %b want 1/0", bus.oState, bus.oError);
    end
    abort_job();
  endtask

  task automatic test_event_wins();
    int kh, mh, bd;
    start_job();
    send_bits(0, KEY_BITS + MSG_BITS, kh, mh, bd);
    bus.iEncrypt_done = 1'b1;
    tick();
    bus.iEncrypt_done = 1'b0;
    repeat (TMO - 1) tick();
    checks++;
    if (bus.oState !== 3'd4) begin
      errors++;
      $display("FAIL drain_full_budget: state %0d want 4", bus.oState);
    end
    bus.iSerial_end = 1'b1;
    tick();
    bus.iSerial_end = 1'b0;
    checks++;
    if (bus.oState !== 3'd5 || bus.oError !== 1'b0) begin
      errors++;
      $display("FAIL event_beats_timeout: state %0d err %b want 5/0", bus.oState, bus.oError);
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    int kh, mh, bd;
    start_job();
    send_bits(0, 17, kh, mh, bd);
    checks++;
    if (bus.oState !== 3'd1 || bus.oLoad_key !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_load: state %0d key %b want 1/1", bus.oState, bus.oLoad_key);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.oData_bit, bus.oLoad_key, bus.oLoad_msg, bus.oBusy, bus.oDone, bus.oError, bus.oState} !== 9'd0) begin
      errors++;
      $display("FAIL async_reset: got %b want 0", {bus.oData_bit, bus.oLoad_key, bus.oLoad_msg, bus.oBusy, bus.oDone, bus.oError, bus.oState});
    end
    tick();
    rst_n = 1'b1;
    start_job();
    send_bits(0, KEY_BITS - 1, kh, mh, bd);
    checks++;
    if (bus.oState !== 3'd1 || kh != KEY_BITS - 1) begin
      errors++;
      $display("FAIL reload_partial: state %0d keys %0d want 1/%0d", bus.oState, kh, KEY_BITS - 1);
    end
    send_bits(KEY_BITS - 1, 1, kh, mh, bd);
    checks++;
    if (bus.oState !== 3'd2) begin
      errors++;
      $display("FAIL reload_key_done: state %0d want 2", bus.oState);
    end
    abort_job();
  endtask

  task automatic test_ena_freeze();
    int kh, mh, bd, strobes;
    start_job();
    send_bits(0, KEY_BITS + 10, kh, mh, bd);
    tick();
    ena = 1'b0;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      bus.iBit_valid = logic'(i % 2 == 0);
      bus.iBit       = logic'(i % 3 == 0);
      tick();
      strobes += int'(bus.oLoad_key) + int'(bus.oLoad_msg);
    end
    checks++;
    if (strobes != 0 || bus.oState !== 3'd2) begin
      errors++;
      $display("FAIL ena_freeze: strobes %0d state %0d want 0/2", strobes, bus.oState);
    end
    bus.iBit_valid = 1'b0;
    ena = 1'b1;
    send_bits(KEY_BITS + 10, MSG_BITS - 11, kh, mh, bd);
    checks++;
    if (bus.oState !== 3'd2 || mh != MSG_BITS - 11) begin
      errors++;
      $display("FAIL ena_resume_count: state %0d msg %0d want 2/%0d", bus.oState, mh, MSG_BITS - 11);
    end
    send_bits(KEY_BITS + MSG_BITS - 1, 1, kh, mh, bd);
    checks++;
    if (bus.oState !== 3'd3) begin
      errors++;
      $display("FAIL ena_resume_end: state %0d want 3", bus.oState);
    end
    abort_job();
  endtask

  task automatic test_abort_start();
    int kh, mh, bd;
    start_job();
    send_bits(0, 3, kh, mh, bd);
    start_job();
    checks++;
    if (bus.oState !== 3'd1) begin
      errors++;
      $display("FAIL start_ignored: state %0d want 1", bus.oState);
    end
    bus.iAbort     = 1'b1;
    bus.iStart     = 1'b1;
    bus.iBit_valid = 1'b1;
    tick();
    bus.iAbort     = 1'b0;
    bus.iStart     = 1'b0;
    bus.iBit_valid = 1'b0;
    checks++;
    if (bus.oState !== 3'd0 || bus.oLoad_key !== 1'b0 || bus.oLoad_msg !== 1'b0 || bus.oBusy !== 1'b0) begin
      errors++;
      $display("FAIL abort_beats_start: state %0d key %b msg %b busy %b want 0/0/0/0", bus.oState, bus.oLoad_key, bus.oLoad_msg, bus.oBusy);
    end
    tick();
    checks++;
    if (bus.oState !== 3'd0) begin
      errors++;
      $display("FAIL abort_stays_idle: state %0d want 0", bus.oState);
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    ena               = 1'b1;
    bus.iStart        = 1'b0;
    bus.iAbort        = 1'b0;
    bus.iBit_valid    = 1'b0;
    bus.iBit          = 1'b0;
    bus.iEncrypt_done = 1'b0;
    bus.iSerial_end   = 1'b0;
    test_reset();
    test_full_job();
    test_timeout();
    test_event_wins();
    test_reset_mid_load();
    test_ena_freeze();
    test_abort_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xor_cipher_sequencer.md
XOR_CIPHER_SEQUENCER -- requirements
Module: xor_cipher_sequencer

Interface
REQ-001 Parameter KEY_SIZE, default 32: key length in bits.
REQ-002 Parameter MSG_SIZE, default 512: message length in bits.
REQ-003 Parameter TIMEOUT, default 1024: cycles allowed each for encrypt and serializer drain.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ena  input  1  enable; when low all state and counters hold.
REQ-007 iStart  input  1  single-cycle job request from host.
REQ-008 iAbort  input  1  host abort; returns to IDLE.
REQ-009 iBit_valid  input  1  host serial bit strobe.
REQ-010 iBit  input  1  host serial data bit.
REQ-011 iEncrypt_done  input  1  from XOR encryptor.
REQ-012 iSerial_end  input  1  from output serializer, last ciphertext bit sent.
REQ-013 oData_bit  output  1  registered copy of iBit to both deserializers.
REQ-014 oLoad_key  output  1  key deserializer load strobe.
REQ-015 oLoad_msg  output  1  message deserializer load strobe.
REQ-016 oBusy  output  1  high in any state except IDLE.
REQ-017 oDone  output  1  one-cycle pulse on job completion.
REQ-018 oError  output  1  sticky timeout flag.
REQ-019 oState  output  3  current state encoding.

Function
REQ-020 States SHALL be IDLE=0, LOAD_KEY=1, LOAD_MSG=2, ENCRYPT=3, DRAIN=4, DONE=5, ERROR=6.
REQ-021 IDLE -> LOAD_KEY on iStart; bit counter cleared to 0.
REQ-022 In LOAD_KEY/LOAD_MSG, each iBit_valid SHALL assert the matching load strobe for exactly the next cycle with oData_bit=iBit, and increment the bit counter.
REQ-023 Load strobes SHALL be low whenever iBit_valid was low the prior cycle; no strobe outside load states.
REQ-024 LOAD_KEY -> LOAD_MSG when the KEY_SIZE-th bit is accepted; counter reset to 0 same edge.
REQ-025 LOAD_MSG -> ENCRYPT when the MSG_SIZE-th bit is accepted; further iBit_valid ignored until next IDLE.
REQ-026 Bit counter width SHALL be clog2(MSG_SIZE)+1; it never wraps (transition occurs at terminal count).
REQ-027 ENCRYPT -> DRAIN on iEncrypt_done; DRAIN -> DONE on iSerial_end.
REQ-028 Wait counter cleared on entering ENCRYPT and DRAIN; reaching TIMEOUT-1 without the awaited event SHALL enter ERROR and set oError.
REQ-029 Event and timeout on same cycle: event wins.
REQ-030 DONE SHALL last exactly one cycle, assert oDone, then return to IDLE.
REQ-031 ERROR holds until iStart (clears oError, enters LOAD_KEY) or iAbort (clears oError, enters IDLE).
REQ-032 iAbort in any state SHALL enter IDLE next cycle with strobes low; iAbort beats iStart when simultaneous.
REQ-033 iStart outside IDLE/ERROR SHALL be ignored.
REQ-034 ena low SHALL freeze state, counters and outputs; strobes forced low.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, counters 0, all outputs 0, including mid-load or mid-drain.
REQ-036 First active edge after rst_n release SHALL behave as IDLE.

Structure
REQ-037 State encoding, default sizes and TIMEOUT SHALL live in shared package xor_cipher_pkg.
REQ-038 One sub-module natural: xor_seq_timer (clearable wait counter with terminal flag); everything else in one FSM.

Verification
REQ-039 Start, 32 key bits then 512 message bits -> oLoad_key high 32 cycles, oLoad_msg high 512 cycles, oState=3 after bit 544.
REQ-040 iEncrypt_done 5 cycles into ENCRYPT, iSerial_end 520 cycles later -> oDone single pulse, oState back to 0, oBusy low.
REQ-041 No iEncrypt_done for 1024 cycles -> oState=6, oError=1; then iStart -> oError=0, oState=1.
REQ-042 rst_n low after key bit 17 -> all outputs 0 asynchronously; new job loads cleanly from bit 0.
REQ-043 ena low for 10 cycles mid LOAD_MSG with iBit_valid toggling -> counter unchanged, no strobes; resumes count on ena high.
REQ-044 iAbort and iStart same cycle in LOAD_KEY -> oState=0, no strobe next cycle.
